// File: rtl/dual_port_rom_pkg.sv
// rtl/dual_port_rom_pkg.sv - shared widths and state types for the dual-port ROM read controller
package dual_port_rom_pkg;
    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} lane_state_t;
    typedef enum logic {PRIO_A, PRIO_B} prio_t;
endpackage

// File: rtl/dual_port_rom_rd_lane.sv
// rtl/dual_port_rom_rd_lane.sv - one client lane: read FSM, response register, optional count (ROM_RD_CNT_EN)
module dual_port_rom_rd_lane
    import dual_port_rom_pkg::*;
#(
    parameter int DATA_W = ROM_DATA_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              rsp_ready,
    input  logic [DATA_W-1:0] rom_data,
    output logic              can_accept,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data
`ifdef ROM_RD_CNT_EN
    ,
    output logic [15:0]       rd_cnt
`endif
);
    lane_state_t state;
    logic        drain;

    assign drain      = (state == HOLD) && rsp_ready;
    // Draining and accepting in one cycle lets back-to-back reads skip the idle bubble.
    assign can_accept = (state == IDLE) || drain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE:  if (accept) state <= ISSUE;
                ISSUE: state <= WAIT;
                WAIT: begin
                    rsp_data  <= rom_data;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= accept ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROM_RD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt <= '0;
        end else if (drain && (rd_cnt != 16'hFFFF)) begin
            rd_cnt <= rd_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: rtl/dual_port_rom_read_ctrl.sv
// rtl/dual_port_rom_read_ctrl.sv - round-robin two-client ROM read controller; ROM_RD_CNT_EN adds read counters
module dual_port_rom_read_ctrl
    import dual_port_rom_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_a_valid_i,
    input  logic [ADDR_W-1:0] req_a_addr_i,
    output logic              req_a_ready_o,
    output logic              rsp_a_valid_o,
    output logic [DATA_W-1:0] rsp_a_data_o,
    input  logic              rsp_a_ready_i,
    input  logic              req_b_valid_i,
    input  logic [ADDR_W-1:0] req_b_addr_i,
    output logic              req_b_ready_o,
    output logic              rsp_b_valid_o,
    output logic [DATA_W-1:0] rsp_b_data_o,
    input  logic              rsp_b_ready_i,
    output logic              rom_en_a_o,
    output logic [ADDR_W-1:0] rom_addr_a_o,
    output logic              rom_en_b_o,
    output logic [ADDR_W-1:0] rom_addr_b_o,
    input  logic [DATA_W-1:0] rom_data_a_i,
    input  logic [DATA_W-1:0] rom_data_b_i
`ifdef ROM_RD_CNT_EN
    ,
    output logic [15:0]       rd_cnt_a_o,
    output logic [15:0]       rd_cnt_b_o
`endif
);
    prio_t prio;
    logic  can_a, can_b, want_a, want_b, grant_a, grant_b;

    assign want_a = can_a && req_a_valid_i;
    assign want_b = can_b && req_b_valid_i;

    // A port's ready looks only at the other port's request, so it never loops through its own valid.
    assign req_a_ready_o = !rst_i && can_a && !(want_b && (prio == PRIO_B));
    assign req_b_ready_o = !rst_i && can_b && !(want_a && (prio == PRIO_A));
    assign grant_a       = req_a_valid_i && req_a_ready_o;
    assign grant_b       = req_b_valid_i && req_b_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio         <= PRIO_A;
            rom_en_a_o   <= 1'b0;
            rom_en_b_o   <= 1'b0;
            rom_addr_a_o <= '0;
            rom_addr_b_o <= '0;
        end else begin
            rom_en_a_o <= grant_a;
            rom_en_b_o <= grant_b;
            if (grant_a) rom_addr_a_o <= req_a_addr_i;
            if (grant_b) rom_addr_b_o <= req_b_addr_i;
            if (want_a && want_b) prio <= (prio == PRIO_A) ? PRIO_B : PRIO_A;
        end
    end

    dual_port_rom_rd_lane #(.DATA_W(DATA_W)) u_lane_a (
        .clk        (clk_i),
        .rst        (rst_i),
        .accept     (grant_a),
        .rsp_ready  (rsp_a_ready_i),
        .rom_data   (rom_data_a_i),
        .can_accept (can_a),
        .rsp_valid  (rsp_a_valid_o),
        .rsp_data   (rsp_a_data_o)
`ifdef ROM_RD_CNT_EN
        ,
        .rd_cnt     (rd_cnt_a_o)
`endif
    );

    dual_port_rom_rd_lane #(.DATA_W(DATA_W)) u_lane_b (
        .clk        (clk_i),
        .rst        (rst_i),
        .accept     (grant_b),
        .rsp_ready  (rsp_b_ready_i),
        .rom_data   (rom_data_b_i),
        .can_accept (can_b),
        .rsp_valid  (rsp_b_valid_o),
        .rsp_data   (rsp_b_data_o)
`ifdef ROM_RD_CNT_EN
        ,
        .rd_cnt     (rd_cnt_b_o)
`endif
    );
endmodule

// File: tb/tb_dual_port_rom_read_ctrl.sv
// tb/tb_dual_port_rom_read_ctrl.sv - scoreboard bench with ROM model for dual_port_rom_read_ctrl
module tb_dual_port_rom_read_ctrl;
    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [1:0]      req_v, rsp_r, req_rdy, rsp_v, en;
    logic [1:0][2:0] req_ad, rom_ad;
    logic [1:0][7:0] rsp_d;
    logic [1:0][7:0] rom_dat = '0;
`ifdef ROM_RD_CNT_EN
    logic [15:0]     rd_cnt_a, rd_cnt_b;
`endif

    logic [7:0] rom_mem [0:7] = '{8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd6, 8'd9};
    string      pfx [2] = '{"a_", "b_"};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int gcnt [2] = '{0, 0};
    int hs_cnt [2] = '{0, 0};
    logic [7:0]      exp_q [2][$];
    int              lat_q [2][$];
    logic [1:0]      acc_prev = '0;
    logic [1:0]      new_rsp = 2'b11;
    logic [1:0][2:0] acc_addr = '0;
    logic            stop_rand = 1'b0;

    always #5 clk_i = ~clk_i;

    dual_port_rom_read_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_a_valid_i (req_v[0]),
        .req_a_addr_i  (req_ad[0]),
        .req_a_ready_o (req_rdy[0]),
        .rsp_a_valid_o (rsp_v[0]),
        .rsp_a_data_o  (rsp_d[0]),
        .rsp_a_ready_i (rsp_r[0]),
        .req_b_valid_i (req_v[1]),
        .req_b_addr_i  (req_ad[1]),
        .req_b_ready_o (req_rdy[1]),
        .rsp_b_valid_o (rsp_v[1]),
        .rsp_b_data_o  (rsp_d[1]),
        .rsp_b_ready_i (rsp_r[1]),
        .rom_en_a_o    (en[0]),
        .rom_addr_a_o  (rom_ad[0]),
        .rom_en_b_o    (en[1]),
        .rom_addr_b_o  (rom_ad[1]),
        .rom_data_a_i  (rom_dat[0]),
        .rom_data_b_i  (rom_dat[1])
`ifdef ROM_RD_CNT_EN
        ,
        .rd_cnt_a_o    (rd_cnt_a),
        .rd_cnt_b_o    (rd_cnt_b)
`endif
    );

    // Registered-read ROM: data appears the cycle after the enable is sampled.
    always @(posedge clk_i) begin
        for (int p = 0; p < 2; p++)
            if (en[p]) rom_dat[p] <= rom_mem[rom_ad[p]];
    end

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted request predicts its data and issue/response timing.
    always @(negedge clk_i) begin
        if (rst_i) begin
            for (int p = 0; p < 2; p++) begin
                exp_q[p].delete();
                lat_q[p].delete();
                hs_cnt[p] = 0;
            end
            acc_prev = '0;
            new_rsp  = 2'b11;
        end else begin
            if (en != 2'b00) chk("rom_en_exclusive", {31'd0, &en}, 0);
            for (int p = 0; p < 2; p++) begin
                chk({pfx[p], "rom_en"}, {31'd0, en[p]}, {31'd0, acc_prev[p]});
                if (acc_prev[p]) chk({pfx[p], "rom_addr"}, {29'd0, rom_ad[p]}, {29'd0, acc_addr[p]});
                if (rsp_v[p] && !rsp_r[p]) chk({pfx[p], "req_ready_while_held"}, {31'd0, req_rdy[p]}, 0);
                if (rsp_v[p] && new_rsp[p]) begin
                    if (lat_q[p].size() == 0) chk({pfx[p], "spurious_rsp"}, 1, 0);
                    else chk({pfx[p], "latency"}, cyc - lat_q[p].pop_front(), 3);
                end
                if (rsp_v[p] && rsp_r[p]) begin
                    if (exp_q[p].size() == 0) chk({pfx[p], "unexpected_rsp"}, 1, 0);
                    else chk({pfx[p], "rsp_data"}, {24'd0, rsp_d[p]}, {24'd0, exp_q[p].pop_front()});
                    hs_cnt[p]++;
                end
                new_rsp[p]  = !rsp_v[p] || rsp_r[p];
                acc_prev[p] = req_v[p] && req_rdy[p];
                if (acc_prev[p]) begin
                    exp_q[p].push_back(rom_mem[req_ad[p]]);
                    lat_q[p].push_back(cyc);
                    acc_addr[p] = req_ad[p];
                    gcnt[p]++;
                end
            end
        end
    end

    task automatic check_zero(input string nm);
        chk({nm, "_ctrl"}, {26'd0, req_rdy, rsp_v, en}, 0);
        chk({nm, "_rsp_data"}, {16'd0, rsp_d}, 0);
        chk({nm, "_rom_addr"}, {26'd0, rom_ad}, 0);
`ifdef ROM_RD_CNT_EN
        chk({nm, "_rd_cnt"}, {rd_cnt_a, rd_cnt_b}, 0);
`endif
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int p, input logic [2:0] a);
        bit ok = 0;
        req_v[p]  = 1'b1;
        req_ad[p] = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (req_rdy[p]) begin ok = 1; break; end
        end
        if (!ok) chk({pfx[p], "send_timeout"}, 1, 0);
        @(posedge clk_i); #1;
        req_v[p] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && rsp_v == 2'b00) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", 1, 0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int da, db, ga, gb;
        bit ok;
        req_v  = '0;
        req_ad = '0;
        rsp_r  = 2'b11;
        repeat (2) @(posedge clk_i);
        #1;
        check_zero("reset");
        rst_i = 1'b0;

        // Single read from A: expects data 64 three cycles after accept.
        send(0, 3'd5);
        wait_idle();

        // Simultaneous requests with priority on A.
        req_v = 2'b11; req_ad[0] = 3'd6; req_ad[1] = 3'd7;
        @(negedge clk_i);
        chk("t2_ready_a", {31'd0, req_rdy[0]}, 1);
        chk("t2_ready_b", {31'd0, req_rdy[1]}, 0);
        @(posedge clk_i); #1;
        req_v[0] = 1'b0;
        @(negedge clk_i);
        chk("t2_ready_b_next", {31'd0, req_rdy[1]}, 1);
        @(posedge clk_i); #1;
        req_v[1] = 1'b0;
        wait_idle();

        // Both ports requesting continuously: grants must stay balanced.
        ga = gcnt[0]; gb = gcnt[1];
        req_v = 2'b11;
        repeat (20) begin
            logic [1:0] acc;
            @(negedge clk_i);
            acc = req_v & req_rdy;
            @(posedge clk_i); #1;
            for (int p = 0; p < 2; p++) if (acc[p]) req_ad[p] = 3'($urandom);
        end
        req_v = '0;
        wait_idle();
        da = gcnt[0] - ga; db = gcnt[1] - gb;
        chk("t3_balance", {31'd0, ((da > db) ? da - db : db - da) <= 1}, 1);
        chk("t3_grants_a", {31'd0, da >= 5}, 1);
        chk("t3_grants_b", {31'd0, db >= 5}, 1);

        // Response held on B while its consumer stalls.
        rsp_r[1] = 1'b0;
        send(1, 3'd3);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (rsp_v[1]) begin ok = 1; break; end
        end
        if (!ok) chk("t4_rsp_timeout", 1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", {31'd0, rsp_v[1]}, 1);
            chk("t4_hold_data", {24'd0, rsp_d[1]}, 32'd16);
            chk("t4_hold_ready", {31'd0, req_rdy[1]}, 0);
            @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        rsp_r[1] = 1'b1;
        @(negedge clk_i);
        chk("t4_drain_ready", {31'd0, req_rdy[1]}, 1);
        wait_idle();

        // Asynchronous reset while A is in WAIT.
        send(0, 3'd4);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        check_zero("t5_async");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (8) begin
            @(negedge clk_i);
            chk("t5_no_rsp", {30'd0, rsp_v}, 0);
        end
        @(posedge clk_i); #1;

        // Randomized traffic with random backpressure.
        stop_rand = 1'b0;
        fork
            begin
                fork
                    for (int k = 0; k < 40; k++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
                        send(0, 3'($urandom));
                    end
                    for (int k = 0; k < 40; k++) begin
                        repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
                        send(1, 3'($urandom));
                    end
                join
                stop_rand = 1'b1;
            end
            while (!stop_rand) begin
                @(posedge clk_i); #1;
                rsp_r = 2'($urandom);
            end
        join
        rsp_r = 2'b11;
        wait_idle();

        // Counted reads from a fresh reset: 3 on A, 2 on B.
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) send(0, 3'($urandom));
        for (int k = 0; k < 2; k++) send(1, 3'($urandom));
        wait_idle();
        chk("t6_handshakes", {hs_cnt[0][15:0], hs_cnt[1][15:0]}, {16'd3, 16'd2});
`ifdef ROM_RD_CNT_EN
        chk("t6_rd_cnt_a", {16'd0, rd_cnt_a}, 3);
        chk("t6_rd_cnt_b", {16'd0, rd_cnt_b}, 2);
`endif
        chk("final_queue_a", exp_q[0].size(), 0);
        chk("final_queue_b", exp_q[1].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
